// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone classic slave data RAM with byte lanes, wait states, range error and abort
module wb_data_ram #(
   parameter int          AW          = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_addr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   localparam logic [3:0] WSL = 4'(WAIT_STATES);
   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            we_q, we_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     wdat_q, wdat_d;
   logic            inr_q, inr_d;
   logic            ack_q, err_q;
   logic [31:0]     rdat_q;
   logic [31:0]     mem_q [2**AW];
   logic            req, inr_i, idle, go;
   logic [AW-1:0]   idx_a;
   logic            we_a, inr_a;
   logic [3:0]      sel_a;
   logic [31:0]     dat_a;
   logic            unused_addr;
   assign unused_addr = &{1'b0, wbs_addr_i[1:0]};
   assign req   = wbs_cyc_i & wbs_stb_i;
   assign inr_i = wbs_addr_i[31:AW+2] == BASE_ADDR[31:AW+2];
   // With zero wait states the access happens on the capture edge, so use the live bus then
   assign idle  = state_q == S_IDLE;
   assign idx_a = idle ? wbs_addr_i[AW+1:2] : idx_q;
   assign we_a  = idle ? wbs_we_i : we_q;
   assign sel_a = idle ? wbs_sel_i : sel_q;
   assign dat_a = idle ? wbs_dat_i : wdat_q;
   assign inr_a = idle ? inr_i : inr_q;
   // Next state, request capture and the one-cycle "enter RESP with cyc high" access strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      inr_d   = inr_q;
      go      = 1'b0;
      case (state_q)
         S_IDLE: if (req) begin
            idx_d  = wbs_addr_i[AW+1:2];
            we_d   = wbs_we_i;
            sel_d  = wbs_sel_i;
            wdat_d = wbs_dat_i;
            inr_d  = inr_i;
            if (WAIT_STATES == 0) begin
               state_d = S_RESP;
               go      = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = WSL - 4'd1;
            end
         end
         S_WAIT: if (!wbs_cyc_i) state_d = S_IDLE;
            else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               go      = 1'b1;
            end else cnt_d = cnt_q - 4'd1;
         default: state_d = S_IDLE;
      endcase
   end
   // State, captured request and registered response outputs
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdat_q  <= '0;
         inr_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         inr_q   <= inr_d;
         ack_q   <= go & inr_a;
         err_q   <= go & ~inr_a;
         rdat_q  <= (go & ~we_a & inr_a) ? mem_q[idx_a] : '0;
      end
   end
   // Byte-lane write, committed only on the edge entering RESP and never under reset
   always_ff @(posedge clk_i) begin
      if (rst_i && go && we_a && inr_a)
         for (int k = 0; k < 4; k++)
            if (sel_a[k]) mem_q[idx_a][8*k +: 8] <= dat_a[8*k +: 8];
   end
   assign wbs_dat_o = rdat_q;
   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram: three RAM instances (0, 2, 3 wait states) against a word-array reference model
module tb_wb_data_ram;
   localparam int          AW   = 10;
   localparam logic [31:0] BASE = 32'h0001_0000;
   typedef logic [41:0] resp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc [3];
   logic        stb [3];
   logic        we  [3];
   logic        ack [3];
   logic        err [3];
   logic [3:0]  sel [3];
   logic [31:0] adr [3];
   logic [31:0] wd  [3];
   logic [31:0] rd  [3];
   logic [31:0] model [3][64];
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_data_ram #(.AW(AW), .BASE_ADDR(BASE), .WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
         .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[g]), .wbs_stb_i(stb[g]),
         .wbs_we_i(we[g]), .wbs_sel_i(sel[g]), .wbs_addr_i(adr[g]), .wbs_dat_i(wd[g]),
         .wbs_dat_o(rd[g]), .wbs_ack_o(ack[g]), .wbs_err_o(err[g]));
   end
   function automatic int ws(input int d);
      return d == 0 ? 0 : d + 1;
   endfunction
   function automatic logic [31:0] wa(input int w);
      return BASE + 32'(w) * 32'd4;
   endfunction
   task automatic mwrite(input int d, input int w, input logic [3:0] s, input logic [31:0] v);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[d][w] = (model[d][w] & ~m) | (v & m);
   endtask
   // Presents a request (call while clk is low) and returns {latency, ack, err, dat} of the first response
   task automatic tx(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] v, output resp_t r);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wd[d] = v;
      r = '0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (ack[d] || err[d]) begin
            r = {8'(i), ack[d], err[d], rd[d]};
            break;
         end
      end
   endtask
   task automatic idle(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if ({ack[d], err[d], rd[d]} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset d%0d: ack=%b err=%b dat=%h, want 0 0 0", d, ack[d], err[d], rd[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_init;
      resp_t r, e;
      logic [31:0] v;
      for (int d = 0; d < 3; d++)
         for (int w = 0; w < 64; w++) begin
            v = $urandom;
            tx(d, 1'b1, wa(w), 4'hF, v, r);
            e = {8'(1 + ws(d)), 2'b10, 32'h0};
            model[d][w] = v;
            n_cmp++;
            if (r !== e) begin
               n_bad++;
               $display("FAIL init_write d%0d w%0d: got %h want %h (lat,ack,err,dat)", d, w, r, e);
            end
            idle(d);
         end
   endtask
   task automatic test_basic;
      resp_t r;
      tx(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, r);
      mwrite(0, 4, 4'hF, 32'hDEADBEEF);
      n_cmp++;
      if (r !== {8'd1, 2'b10, 32'h0}) begin
         n_bad++;
         $display("FAIL basic_write: got %h want %h", r, {8'd1, 2'b10, 32'h0});
      end
      idle(0);
      n_cmp++;
      if ({ack[0], err[0]} !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_ack_width: ack/err=%b want 00", {ack[0], err[0]});
      end
      tx(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, r);
      n_cmp++;
      if (r !== {8'd1, 2'b10, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL basic_read: got %h want %h", r, {8'd1, 2'b10, 32'hDEADBEEF});
      end
      idle(0);
   endtask
   task automatic test_byte_lane;
      resp_t r, e;
      for (int d = 0; d < 3; d++) begin
         tx(d, 1'b1, wa(5), 4'hF, 32'h11223344, r); mwrite(d, 5, 4'hF, 32'h11223344); idle(d);
         tx(d, 1'b1, wa(5), 4'b0010, 32'hAABBCCDD, r); mwrite(d, 5, 4'b0010, 32'hAABBCCDD); idle(d);
         tx(d, 1'b0, wa(5), 4'hF, 32'h0, r); idle(d);
         e = {8'(1 + ws(d)), 2'b10, model[d][5]};
         n_cmp++;
         if (r !== e || model[d][5] !== 32'h1122CC44) begin
            n_bad++;
            $display("FAIL byte_lane d%0d: got %h want %h", d, r, e);
         end
         tx(d, 1'b1, wa(5), 4'b0000, 32'hFFFFFFFF, r); idle(d);
         e = {8'(1 + ws(d)), 2'b10, 32'h0};
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL sel0_ack d%0d: got %h want %h", d, r, e);
         end
         tx(d, 1'b0, wa(5), 4'hF, 32'h0, r); idle(d);
         e = {8'(1 + ws(d)), 2'b10, model[d][5]};
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL sel0_unchanged d%0d: got %h want %h", d, r, e);
         end
      end
   endtask
   task automatic test_range;
      resp_t r, e;
      for (int d = 0; d < 3; d++) begin
         e = {8'(1 + ws(d)), 2'b01, 32'h0};
         tx(d, 1'b0, BASE + (32'd4 << AW), 4'hF, 32'h0, r); idle(d);
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL range_read d%0d: got %h want %h", d, r, e);
         end
         tx(d, 1'b1, BASE + (32'd4 << AW), 4'hF, ~model[d][0], r); idle(d);
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL range_write d%0d: got %h want %h", d, r, e);
         end
         tx(d, 1'b0, BASE - 32'd4, 4'hF, 32'h0, r); idle(d);
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL range_below d%0d: got %h want %h", d, r, e);
         end
         tx(d, 1'b0, wa(0), 4'hF, 32'h0, r); idle(d);
         e = {8'(1 + ws(d)), 2'b10, model[d][0]};
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL range_no_alias d%0d: got %h want %h", d, r, e);
         end
      end
   endtask
   task automatic test_wait;
      resp_t r, e;
      tx(1, 1'b0, wa(4), 4'hF, 32'h0, r);
      e = {8'd3, 2'b10, model[1][4]};
      n_cmp++;
      if (r !== e) begin
         n_bad++;
         $display("FAIL wait_latency: got %h want %h", r, e);
      end
      idle(1);
      n_cmp++;
      if ({ack[1], err[1]} !== 2'b00) begin
         n_bad++;
         $display("FAIL wait_cycle4: ack/err=%b want 00", {ack[1], err[1]});
      end
      for (int i = 0; i < 4; i++) begin
         tx(1, 1'b0, wa(10 + i), 4'hF, 32'h0, r);
         e = {8'(i == 0 ? 3 : 4), 2'b10, model[1][10 + i]};
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL back_to_back #%0d: got %h want %h", i, r, e);
         end
      end
      idle(1);
   endtask
   task automatic test_wait_ignore;
      int hit;
      logic [31:0] dat;
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = wa(3); sel[2] = 4'hF; wd[2] = 32'h0;
      @(negedge clk);
      stb[2] = 1'b0; we[2] = 1'b1; adr[2] = wa(4); wd[2] = ~model[2][4];
      hit = 0; dat = 32'h0;
      for (int i = 2; i <= 8 && hit == 0; i++) begin
         @(negedge clk);
         if (ack[2] || err[2]) begin hit = i; dat = rd[2]; end
      end
      n_cmp++;
      if (hit !== 4 || dat !== model[2][3]) begin
         n_bad++;
         $display("FAIL wait_ignore: got cycle %0d dat %h, want cycle 4 dat %h", hit, dat, model[2][3]);
      end
      idle(2);
   endtask
   task automatic test_abort;
      resp_t r, e;
      int seen;
      for (int c = 1; c <= 3; c++) begin
         cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = wa(7); sel[2] = 4'hF; wd[2] = 32'h5A5A5A5A;
         repeat (c) @(negedge clk);
         cyc[2] = 1'b0; stb[2] = 1'b0;
         seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen++;
         end
         n_cmp++;
         if (seen != 0) begin
            n_bad++;
            $display("FAIL abort_cycle%0d: %0d responses, want 0", c, seen);
         end
         tx(2, 1'b0, wa(7), 4'hF, 32'h0, r); idle(2);
         e = {8'd4, 2'b10, model[2][7]};
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL abort_no_write%0d: got %h want %h", c, r, e);
         end
      end
   endtask
   task automatic test_reset_mid;
      resp_t r, e;
      int seen;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = wa(9); sel[1] = 4'hF; wd[1] = ~model[1][9];
      @(negedge clk);
      rst_n = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if ({ack[1], err[1], rd[1]} !== 34'h0) begin
         n_bad++;
         $display("FAIL reset_mid_outputs: ack=%b err=%b dat=%h, want 0 0 0", ack[1], err[1], rd[1]);
      end
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (ack[1] || err[1]) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL reset_mid_resp: %0d responses, want 0", seen);
      end
      tx(1, 1'b0, wa(9), 4'hF, 32'h0, r); idle(1);
      e = {8'd3, 2'b10, model[1][9]};
      n_cmp++;
      if (r !== e) begin
         n_bad++;
         $display("FAIL reset_mid_word: got %h want %h", r, e);
      end
   endtask
   task automatic test_random;
      resp_t r, e;
      logic w, oor, b2b;
      logic [3:0] s;
      logic [31:0] a, v;
      int wi;
      for (int d = 0; d < 3; d++)
         for (int n = 0; n < 60; n++) begin
            w   = 1'($urandom);
            wi  = $urandom_range(0, 63);
            oor = ($urandom % 6) == 0;
            a   = oor ? (wa(wi) ^ (32'h1 << $urandom_range(AW + 2, 31))) : wa(wi);
            s   = 4'($urandom);
            v   = $urandom;
            b2b = n != 0 && 1'($urandom);
            if (n != 0 && !b2b) idle(d);
            e = {8'((b2b ? 2 : 1) + ws(d)), !oor, oor, (!w && !oor) ? model[d][wi] : 32'h0};
            tx(d, w, a, s, v, r);
            if (w && !oor) mwrite(d, wi, s, v);
            n_cmp++;
            if (r !== e) begin
               n_bad++;
               $display("FAIL random d%0d #%0d we=%b a=%h: got %h want %h", d, n, w, a, r, e);
            end
         end
      for (int d = 0; d < 3; d++) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
      @(negedge clk);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = 32'h0; wd[d] = 32'h0;
      end
      test_reset;
      test_init;
      test_basic;
      test_byte_lane;
      test_range;
      test_wait;
      test_wait_ignore;
      test_abort;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
